dsplit_s4: RTL and testbench

Tagged-data dispatcher on the execution-unit output side: accepts one 64-bit data word plus tag per cycle from the EU and routes it to the local memory, stream controller, network controller or one of three neighbour links (H, V, D). It is the transmit counterpart of the EU's result multiplexer. Per-destination credit counters mirror the 16-entry receive FIFOs at each far end, so no destination FIFO can overflow.

---
 rtl/dsplit_s4_pkg.sv | 24 ++
 rtl/dsplit_s4_if.sv | 38 +++
 rtl/dsplit_s4_credit.sv | 37 +++
 rtl/dsplit_s4.sv | 102 ++++++++++
 tb/tb_dsplit_s4.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/dsplit_s4_pkg.sv
// Shared types for the dsplit_s4 tagged-data dispatcher: destination codes,
// destination count and data width.
package dsplit_pkg;

    typedef enum logic [2:0] {
        DST_LOCAL  = 3'd0,
        DST_STREAM = 3'd1,
        DST_NET    = 3'd2,
        DST_H      = 3'd3,
        DST_V      = 3'd4,
        DST_D      = 3'd5,
        DST_INV    = 3'd6,
        DST_BCAST  = 3'd7
    } dest_t;

    localparam int NDEST  = 6;
    localparam int DATA_W = 64;

    // Codes 0..5 address exactly one destination.
    function automatic logic is_unicast(dest_t d);
        return d <= DST_D;
    endfunction

endpackage

// File: rtl/dsplit_s4_if.sv
// EU-side handshake plus the six destination links of dsplit_s4.
// master = EU/far-end side, slave = dispatcher.
interface dsplit_s4_if #(parameter int TagWidth = 11);

    localparam int WW = TagWidth + 64;

    logic                IVALID;
    logic                IREADY;
    logic [2:0]          IDEST;
    logic [TagWidth-1:0] ITAG;
    logic [63:0]         IDATA;

    logic LocalDRDY, StreamDRDY, NetDRDY, DRDYH, DRDYV, DRDYD;
    logic [WW-1:0] LocalDATA, StreamDATA, NetDATA, DATAH, DATAV, DATAD;
    logic LocalCRET, StreamCRET, NetCRET, CRETH, CRETV, CRETD;

    logic ERR;
    logic CROVF;

    modport master (
        output IVALID, IDEST, ITAG, IDATA,
        output LocalCRET, StreamCRET, NetCRET, CRETH, CRETV, CRETD,
        input  IREADY,
        input  LocalDRDY, StreamDRDY, NetDRDY, DRDYH, DRDYV, DRDYD,
        input  LocalDATA, StreamDATA, NetDATA, DATAH, DATAV, DATAD,
        input  ERR, CROVF
    );

    modport slave (
        input  IVALID, IDEST, ITAG, IDATA,
        input  LocalCRET, StreamCRET, NetCRET, CRETH, CRETV, CRETD,
        output IREADY,
        output LocalDRDY, StreamDRDY, NetDRDY, DRDYH, DRDYV, DRDYD,
        output LocalDATA, StreamDATA, NetDATA, DATAH, DATAV, DATAD,
        output ERR, CROVF
    );

endinterface

// File: rtl/dsplit_s4_credit.sv
// One per-destination credit counter mirroring a far-end receive FIFO.
// Starts full, saturates at CREDITS, flags a sticky overflow on a surplus return.
module dsplit_credit #(
    parameter int CREDITS = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic dec,
    input  logic inc,
    output logic nonzero,
    output logic ovf
);

    localparam int            CW   = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count <= FULL;
            ovf   <= 1'b0;
        end else begin
            if (inc && count == FULL) ovf <= 1'b1;
            if (dec && !inc) begin
                count <= count - CW'(1);
            end else if (inc && !dec && count != FULL) begin
                count <= count + CW'(1);
            end
        end
    end

    assign nonzero = (count != '0);

endmodule

// File: rtl/dsplit_s4.sv
// dsplit_s4: routes one {tag, data} word per cycle from the EU to one of six
// credit-tracked destinations. Optional broadcast to H/V/D: DSPLIT_BCAST_EN.
module dsplit_s4
    import dsplit_pkg::*;
#(
    parameter int TagWidth = 11,
    parameter int CREDITS  = 16
) (
    input logic         CLK,
    input logic         RESET,
    dsplit_s4_if.slave  bus
);

    typedef struct packed {
        logic [TagWidth-1:0] tag;
        logic [DATA_W-1:0]   data;
    } word_t;

    dest_t            dest;
    word_t            word;
    logic [NDEST-1:0] nz, cret, sel, take, ovf, drdy_q;
    logic             ready, bad, accept, err_q;
    word_t            data_q [NDEST];

    assign dest = dest_t'(bus.IDEST);
    assign word = {bus.ITAG, bus.IDATA};
    assign cret = {bus.CRETD, bus.CRETV, bus.CRETH,
                   bus.NetCRET, bus.StreamCRET, bus.LocalCRET};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        ready = 1'b1;
        sel   = '0;
        bad   = 1'b0;
        if (is_unicast(dest)) begin
            for (int k = 0; k < NDEST; k++) begin
                if (bus.IDEST == 3'(k)) begin
                    ready  = nz[k];
                    sel[k] = 1'b1;
                end
            end
        end
`ifdef DSPLIT_BCAST_EN
        else if (dest == DST_BCAST) begin
            ready = nz[DST_H] & nz[DST_V] & nz[DST_D];
            sel   = 6'b111000;
        end
`endif
        else begin
            bad = 1'b1;
        end
    end

    // IREADY is a function of IDEST and credit state only; IVALID only qualifies accept.
    assign bus.IREADY = ~RESET & ready;
    assign accept     = bus.IVALID & ~RESET & ready;
    assign take       = sel & {NDEST{accept}};

    for (genvar k = 0; k < NDEST; k++) begin : g_credit
        dsplit_credit #(.CREDITS(CREDITS)) u_credit (
            .CLK     (CLK),
            .RESET   (RESET),
            .dec     (take[k]),
            .inc     (cret[k]),
            .nonzero (nz[k]),
            .ovf     (ovf[k])
        );
    end

    // NOTE: the data registers are reset too, because outputs must read 0 out of reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            drdy_q <= '0;
            err_q  <= 1'b0;
            for (int k = 0; k < NDEST; k++) data_q[k] <= '0;
        end else begin
            drdy_q <= take;
            err_q  <= accept & bad;
            for (int k = 0; k < NDEST; k++) begin
                if (take[k]) data_q[k] <= word;
            end
        end
    end

    assign bus.LocalDRDY  = drdy_q[DST_LOCAL];
    assign bus.StreamDRDY = drdy_q[DST_STREAM];
    assign bus.NetDRDY    = drdy_q[DST_NET];
    assign bus.DRDYH      = drdy_q[DST_H];
    assign bus.DRDYV      = drdy_q[DST_V];
    assign bus.DRDYD      = drdy_q[DST_D];

    assign bus.LocalDATA  = data_q[DST_LOCAL];
    assign bus.StreamDATA = data_q[DST_STREAM];
    assign bus.NetDATA    = data_q[DST_NET];
    assign bus.DATAH      = data_q[DST_H];
    assign bus.DATAV      = data_q[DST_V];
    assign bus.DATAD      = data_q[DST_D];

    assign bus.ERR   = err_q;
    assign bus.CROVF = |ovf;

endmodule

// File: tb/tb_dsplit_s4.sv
// Self-checking bench for dsplit_s4: directed scenarios plus randomized traffic
// scored against a credit/queue-level reference model.
module tb_dsplit_s4;
    import dsplit_pkg::*;

    localparam int TW = 11;
    localparam int CR = 16;
    localparam int WW = TW + 64;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    dsplit_s4_if #(.TagWidth(TW)) bus ();

    dsplit_s4 #(.TagWidth(TW), .CREDITS(CR)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    int          credit   [NDEST];
    logic [WW-1:0] exp_data [NDEST];
    bit          exp_ovf;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] get_drdy();
        return {bus.DRDYD, bus.DRDYV, bus.DRDYH, bus.NetDRDY, bus.StreamDRDY, bus.LocalDRDY};
    endfunction

    function automatic logic [WW-1:0] get_data(input int k);
        case (k)
            0:       return bus.LocalDATA;
            1:       return bus.StreamDATA;
            2:       return bus.NetDATA;
            3:       return bus.DATAH;
            4:       return bus.DATAV;
            default: return bus.DATAD;
        endcase
    endfunction

    task automatic drive(input bit valid, input int dest, input logic [TW-1:0] tag,
                         input logic [63:0] data, input logic [5:0] cret);
        bus.IVALID     = valid;
        bus.IDEST      = 3'(dest);
        bus.ITAG       = tag;
        bus.IDATA      = data;
        bus.LocalCRET  = cret[0];
        bus.StreamCRET = cret[1];
        bus.NetCRET    = cret[2];
        bus.CRETH      = cret[3];
        bus.CRETV      = cret[4];
        bus.CRETD      = cret[5];
    endtask

    task automatic check_outputs(input logic [5:0] exp_drdy, input bit exp_err);
        check("drdy", 128'(get_drdy()), 128'(exp_drdy));
        check("err", 128'(bus.ERR), 128'(exp_err));
        check("crovf", 128'(bus.CROVF), 128'(exp_ovf));
        for (int k = 0; k < NDEST; k++)
            check($sformatf("data%0d", k), 128'(get_data(k)), 128'(exp_data[k]));
    endtask

    // One clock: drive, check IREADY, advance the model, check registered outputs.
    task automatic cycle(input bit valid, input int dest, input logic [TW-1:0] tag,
                         input logic [63:0] data, input logic [5:0] cret);
        bit         r, acc, exp_err;
        logic [5:0] exp_drdy;
        drive(valid, dest, tag, data, cret);
        #1;
        if (dest < NDEST) r = (credit[dest] > 0);
`ifdef DSPLIT_BCAST_EN
        else if (dest == 7) r = (credit[3] > 0) && (credit[4] > 0) && (credit[5] > 0);
`endif
        else r = 1'b1;
        check("iready", 128'(bus.IREADY), 128'(r));
        acc      = valid && r;
        exp_drdy = '0;
        exp_err  = 1'b0;
        if (acc) begin
            if (dest < NDEST) exp_drdy[dest] = 1'b1;
`ifdef DSPLIT_BCAST_EN
            else if (dest == 7) exp_drdy = 6'b111000;
`endif
            else exp_err = 1'b1;
        end
        for (int k = 0; k < NDEST; k++) begin
            if (exp_drdy[k]) exp_data[k] = {tag, data};
            if (cret[k] && credit[k] == CR) exp_ovf = 1'b1;
            credit[k] = credit[k] - int'(exp_drdy[k]) + int'(cret[k]);
            if (credit[k] > CR) credit[k] = CR;
        end
        @(posedge CLK);
        #1;
        check_outputs(exp_drdy, exp_err);
    endtask

    // Reset with a live request present: it must not be accepted.
    task automatic do_reset();
        RESET = 1'b1;
        drive(1'b1, 0, 11'h7ff, 64'hFFFF_0000_FFFF_0000, 6'b0);
        #1;
        check("iready_rst", 128'(bus.IREADY), 128'(0));
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        drive(1'b0, 0, '0, '0, 6'b0);
        for (int k = 0; k < NDEST; k++) begin
            credit[k]   = CR;
            exp_data[k] = '0;
        end
        exp_ovf = 1'b0;
        check_outputs(6'b0, 1'b0);
    endtask

    initial begin
        RESET = 1'b1;
        drive(1'b0, 0, '0, '0, 6'b0);
        repeat (2) @(posedge CLK);
        #1;
        do_reset();

        // Single word to Net.
        cycle(1'b1, 2, 11'd5, 64'h1234, 6'b0);
        cycle(1'b0, 0, '0, '0, 6'b0);

        // Drain H, stall on the 17th, one credit return releases it.
        do_reset();
        for (int i = 0; i < CR; i++) cycle(1'b1, 3, TW'(i), 64'(i) * 64'h1111, 6'b0);
        cycle(1'b1, 3, 11'h17, 64'hABCD, 6'b0);
        cycle(1'b1, 3, 11'h17, 64'hABCD, 6'b001000);
        cycle(1'b1, 3, 11'h17, 64'hABCD, 6'b0);
        cycle(1'b1, 3, 11'h18, 64'hBEEF, 6'b0);

        // V at credit 1: send with same-cycle return keeps it at 1.
        do_reset();
        for (int i = 0; i < CR - 1; i++) cycle(1'b1, 4, TW'(i), 64'(i), 6'b0);
        cycle(1'b1, 4, 11'h20, 64'h2020, 6'b010000);
        cycle(1'b1, 4, 11'h21, 64'h2121, 6'b0);
        cycle(1'b1, 4, 11'h22, 64'h2222, 6'b0);

        // Invalid code and code 7.
        do_reset();
        cycle(1'b1, 6, 11'h3, 64'hDEAD, 6'b0);
        cycle(1'b1, 7, 11'h44, 64'hCAFE_F00D, 6'b0);
        cycle(1'b1, 3, 11'h45, 64'h1, 6'b0);
        cycle(1'b0, 0, '0, '0, 6'b0);

        // Randomized traffic with far ends returning credit only for words they hold.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            int         r, d;
            logic [5:0] cr;
            r = int'($urandom_range(0, 15));
            d = (r < 12) ? r % NDEST : ((r < 14) ? 6 : 7);
            for (int k = 0; k < NDEST; k++)
                cr[k] = (credit[k] < CR) && ($urandom_range(0, 15) == 0);
            cycle($urandom_range(0, 7) != 0, d, TW'($urandom_range(0, 2047)),
                  {$urandom, $urandom}, cr);
        end

        // Mid-operation reset discards the pending word; then credit overflow on D.
        cycle(1'b1, 0, 11'h1, 64'h55, 6'b0);
        do_reset();
        cycle(1'b0, 0, '0, '0, 6'b100000);
        cycle(1'b0, 0, '0, '0, 6'b0);
        cycle(1'b1, 5, 11'h9, 64'h99, 6'b0);
        for (int i = 0; i < CR - 1; i++) cycle(1'b1, 5, TW'(i), 64'(i), 6'b0);
        cycle(1'b1, 5, 11'h9, 64'h99, 6'b0);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
